// File: rtl/icmp_echo_ctrl_pkg.sv
// Shared constants for the ICMP echo controller: FSM state encoding and the
// largest echo payload that fits an untagged Ethernet MTU.
package icmp_echo_ctrl_pkg;

    localparam int unsigned ETH_MTU_PAYLOAD = 1472;

    typedef enum logic [6:0] {
        ST_IDLE      = 7'b0000001,
        ST_RECV      = 7'b0000010,
        ST_DROP_WAIT = 7'b0000100,
        ST_WAIT_DV   = 7'b0001000,
        ST_SETTLE    = 7'b0010000,
        ST_START     = 7'b0100000,
        ST_TX        = 7'b1000000
    } state_e;

endpackage

// File: rtl/icmp_echo_buf.sv
// Echo payload buffer: simple dual-port RAM, one write port and one
// registered read port.
module icmp_echo_buf #(
    parameter int unsigned DEPTH = 1472,
    parameter int unsigned AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/icmp_echo_ctrl.sv
// Sequences one ICMP echo: buffers the request payload, captures id/seq and
// the settled checksum, then starts the transmitter and serves its byte reads.
module icmp_echo_ctrl
    import icmp_echo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH        = ETH_MTU_PAYLOAD,
    parameter int unsigned AW           = 11,
    parameter int unsigned CKSUM_SETTLE = 2,
    parameter int unsigned TX_TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic        rec_en,
    input  logic [7:0]  rec_data,
    input  logic        rec_pkt_done,
    input  logic [15:0] rec_byte_num,
    input  logic [15:0] icmp_id,
    input  logic [15:0] icmp_seq,
    input  logic [31:0] reply_checksum,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [15:0] tx_id,
    output logic [15:0] tx_seq,
    output logic [31:0] tx_checksum,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    state_e      state_q, state_d;
    logic [15:0] wr_cnt_q, rd_addr_q;
    logic        ovf_q;
    logic [7:0]  settle_q;
    logic [31:0] to_cnt_q;
    logic        rd_vld_q;
    logic [7:0]  tx_data_q;
    logic [7:0]  rdata;

    logic        in_rx, in_busy, wr_room, wr_fire, ovf_nxt;
    logic [15:0] cnt_nxt;
    logic        done_chk, accept, reject, busy_drop;
    logic        rd_fire, tx_exit, dv_low_drop, dv_low_wait;

    // The done-check sees the count including a coincident final byte.
    always_comb begin
        in_rx       = (state_q == ST_IDLE) || (state_q == ST_RECV);
        in_busy     = (state_q == ST_WAIT_DV) || (state_q == ST_SETTLE) ||
                      (state_q == ST_START) || (state_q == ST_TX);
        wr_room     = wr_cnt_q < 16'(DEPTH);
        wr_fire     = in_rx && rec_en && wr_room;
        ovf_nxt     = ovf_q || (in_rx && rec_en && !wr_room);
        cnt_nxt     = wr_cnt_q + {15'd0, wr_fire};
        done_chk    = rec_pkt_done &&
                      (((state_q == ST_IDLE) && rec_en) || (state_q == ST_RECV));
        accept      = done_chk && !ovf_nxt && (rec_byte_num == cnt_nxt);
        reject      = done_chk && !accept;
        busy_drop   = rec_pkt_done && in_busy;
        rd_fire     = (state_q == ST_TX) && tx_req && (rd_addr_q != tx_byte_num);
        tx_exit     = (state_q == ST_TX) && (tx_done || (to_cnt_q == TX_TIMEOUT));
        dv_low_drop = (state_q == ST_DROP_WAIT) && !gmii_rx_dv;
        dv_low_wait = (state_q == ST_WAIT_DV) && !gmii_rx_dv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rec_en) begin
                    if (accept)      state_d = ST_WAIT_DV;
                    else if (reject) state_d = ST_DROP_WAIT;
                    else             state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (accept)      state_d = ST_WAIT_DV;
                else if (reject) state_d = ST_DROP_WAIT;
            end
            ST_DROP_WAIT: if (!gmii_rx_dv)      state_d = ST_IDLE;
            ST_WAIT_DV:   if (!gmii_rx_dv)      state_d = ST_SETTLE;
            ST_SETTLE:    if (settle_q == '0)   state_d = ST_START;
            ST_START:                           state_d = ST_TX;
            ST_TX:        if (tx_exit)          state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        tx_start_en = (state_q == ST_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            rd_addr_q   <= '0;
            settle_q    <= '0;
            to_cnt_q    <= '0;
            rd_vld_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_byte_num <= '0;
            tx_id       <= '0;
            tx_seq      <= '0;
            tx_checksum <= '0;
            drop_cnt    <= '0;
        end else begin
            rd_vld_q  <= rd_fire;
            tx_data_q <= tx_data;

            if (wr_fire) wr_cnt_q <= cnt_nxt;
            if (in_rx)   ovf_q    <= ovf_nxt;

            if (accept) begin
                tx_byte_num <= rec_byte_num;
                tx_id       <= icmp_id;
                tx_seq      <= icmp_seq;
            end

            if (dv_low_wait) begin
                settle_q <= 8'(CKSUM_SETTLE - 1);
            end else if (state_q == ST_SETTLE) begin
                if (settle_q == '0) tx_checksum <= reply_checksum;
                else                settle_q    <= settle_q - 8'd1;
            end

            if (state_q == ST_START) begin
                rd_addr_q <= '0;
                to_cnt_q  <= '0;
            end else if (state_q == ST_TX) begin
                to_cnt_q <= to_cnt_q + 32'd1;
                if (rd_fire) rd_addr_q <= rd_addr_q + 16'd1;
            end

            // Exit clears take priority over the same-cycle read increment.
            if (dv_low_drop || tx_exit) begin
                wr_cnt_q <= '0;
                ovf_q    <= 1'b0;
            end
            if (tx_exit) begin
                rd_addr_q <= '0;
                to_cnt_q  <= '0;
            end

            if ((reject || busy_drop) && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // tx_data follows the RAM for one cycle after a served read, then holds.
    assign tx_data = rd_vld_q ? rdata : tx_data_q;

    icmp_echo_buf #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_buf (
        .clk  (clk),
        .we   (wr_fire),
        .waddr(wr_cnt_q[AW-1:0]),
        .wdata(rec_data),
        .raddr(rd_addr_q[AW-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_icmp_echo_ctrl.sv
// Directed bench for icmp_echo_ctrl: a default instance plus one with a short
// transmit timeout, driven from the same inputs.
module tb_icmp_echo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic        rec_en = 1'b0;
    logic [7:0]  rec_data = '0;
    logic        rec_pkt_done = 1'b0;
    logic [15:0] rec_byte_num = '0;
    logic [15:0] icmp_id = '0;
    logic [15:0] icmp_seq = '0;
    logic [31:0] reply_checksum = '0;
    logic        tx_req = 1'b0;
    logic        tx_done = 1'b0;

    logic        tx_start_en, busy;
    logic [15:0] tx_byte_num, tx_id, tx_seq, drop_cnt;
    logic [31:0] tx_checksum;
    logic [7:0]  tx_data;

    logic        t_tx_start_en, t_busy;
    logic [15:0] t_tx_byte_num, t_tx_id, t_tx_seq, t_drop_cnt;
    logic [31:0] t_tx_checksum;
    logic [7:0]  t_tx_data;

    int total = 0;
    int bad = 0;
    int start_seen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (tx_start_en) start_seen <= start_seen + 1;

    icmp_echo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .rec_en(rec_en),
        .rec_data(rec_data), .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
        .icmp_id(icmp_id), .icmp_seq(icmp_seq), .reply_checksum(reply_checksum),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num), .tx_id(tx_id), .tx_seq(tx_seq),
        .tx_checksum(tx_checksum), .tx_data(tx_data), .busy(busy), .drop_cnt(drop_cnt)
    );

    icmp_echo_ctrl #(.TX_TIMEOUT(16)) dut_to (
        .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .rec_en(rec_en),
        .rec_data(rec_data), .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
        .icmp_id(icmp_id), .icmp_seq(icmp_seq), .reply_checksum(reply_checksum),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(t_tx_start_en),
        .tx_byte_num(t_tx_byte_num), .tx_id(t_tx_id), .tx_seq(t_tx_seq),
        .tx_checksum(t_tx_checksum), .tx_data(t_tx_data), .busy(t_busy),
        .drop_cnt(t_drop_cnt)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; gmii_rx_dv = 1'b0; rec_en = 1'b0; rec_pkt_done = 1'b0;
        tx_req = 1'b0; tx_done = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    // n payload strobes with dv high; done pulse on the last; dv left high.
    task automatic send_bytes(input int n, input logic [15:0] num, input logic [7:0] base);
        gmii_rx_dv = 1'b1;
        for (int i = 0; i < n; i++) begin
            rec_en = 1'b1;
            rec_data = base + 8'(i);
            rec_pkt_done = (i == n - 1);
            rec_byte_num = num;
            tick();
        end
        rec_en = 1'b0; rec_pkt_done = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        total++; if ({busy, tx_start_en, tx_byte_num, tx_id, tx_seq, tx_checksum, tx_data, drop_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs got busy=%0h start=%0h num=%0h id=%0h seq=%0h ck=%0h data=%0h drop=%0h exp all 0",
                            busy, tx_start_en, tx_byte_num, tx_id, tx_seq, tx_checksum, tx_data, drop_cnt);
        end
    endtask

    task automatic test_nominal;
        int s0;
        s0 = start_seen;
        icmp_id = 16'h0001; icmp_seq = 16'h0005; reply_checksum = 32'hDEAD_BEEF;
        send_bytes(32, 16'd32, 8'h00);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL nom_busy got=%0h exp=1", busy); end
        total++; if ({tx_byte_num, tx_id, tx_seq} !== {16'd32, 16'h0001, 16'h0005}) begin
            bad++; $display("FAIL nom_latch got num=%0h id=%0h seq=%0h exp 20/1/5", tx_byte_num, tx_id, tx_seq);
        end
        gmii_rx_dv = 1'b0;
        tick();
        reply_checksum = 32'h0001_0F0F;
        tick();
        total++; if (tx_start_en !== 1'b0) begin bad++; $display("FAIL nom_start_early got=%0h exp=0", tx_start_en); end
        tick();
        total++; if (tx_start_en !== 1'b1) begin bad++; $display("FAIL nom_start got=%0h exp=1", tx_start_en); end
        total++; if (tx_checksum !== 32'h0001_0F0F) begin bad++; $display("FAIL nom_cksum got=%0h exp=10f0f", tx_checksum); end
        reply_checksum = 32'h1234_5678;
        tick();
        total++; if (tx_start_en !== 1'b0) begin bad++; $display("FAIL nom_start_once got=%0h exp=0", tx_start_en); end
        for (int i = 0; i < 32; i++) begin
            tx_req = 1'b1;
            tick();
            total++; if (tx_data !== 8'(i)) begin bad++; $display("FAIL nom_data[%0d] got=%0h exp=%0h", i, tx_data, 8'(i)); end
        end
        tick();
        tx_req = 1'b0;
        total++; if (tx_data !== 8'h1F) begin bad++; $display("FAIL nom_past_end got=%0h exp=1f", tx_data); end
        total++; if (tx_checksum !== 32'h0001_0F0F) begin bad++; $display("FAIL nom_cksum_hold got=%0h exp=10f0f", tx_checksum); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nom_busy_end got=%0h exp=0", busy); end
        total++; if (start_seen - s0 !== 1) begin bad++; $display("FAIL nom_start_count got=%0d exp=1", start_seen - s0); end
    endtask

    task automatic test_mismatch;
        int s0, d0;
        s0 = start_seen; d0 = drop_cnt;
        send_bytes(10, 16'd12, 8'h40);
        total++; if (drop_cnt !== 16'(d0 + 1)) begin bad++; $display("FAIL mis_drop got=%0d exp=%0d", drop_cnt, d0 + 1); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mis_busy_dv got=%0h exp=1", busy); end
        gmii_rx_dv = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_idle got=%0h exp=0", busy); end
        tick(5);
        total++; if (start_seen !== s0) begin bad++; $display("FAIL mis_no_start got=%0d exp=%0d", start_seen, s0); end
    endtask

    task automatic test_overflow;
        int s0, d0;
        s0 = start_seen; d0 = drop_cnt;
        send_bytes(1473, 16'd1473, 8'h00);
        gmii_rx_dv = 1'b0;
        tick(6);
        total++; if (drop_cnt !== 16'(d0 + 1)) begin bad++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_cnt, d0 + 1); end
        total++; if ({busy, 32'(start_seen)} !== {1'b0, 32'(s0)}) begin
            bad++; $display("FAIL ovf_no_start got busy=%0h starts=%0d exp 0/%0d", busy, start_seen, s0);
        end
        send_bytes(1472, 16'd1472, 8'h00);
        gmii_rx_dv = 1'b0;
        tick(4);
        total++; if ({tx_byte_num, 32'(start_seen)} !== {16'd1472, 32'(s0 + 1)}) begin
            bad++; $display("FAIL full_accept got num=%0d starts=%0d exp 1472/%0d", tx_byte_num, start_seen, s0 + 1);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end got=%0h exp=0", busy); end
    endtask

    task automatic test_single_byte;
        icmp_id = 16'hABCD; icmp_seq = 16'h0102;
        send_bytes(1, 16'd1, 8'h77);
        total++; if ({busy, tx_byte_num, tx_id} !== {1'b1, 16'd1, 16'hABCD}) begin
            bad++; $display("FAIL one_accept got busy=%0h num=%0h id=%0h exp 1/1/abcd", busy, tx_byte_num, tx_id);
        end
        gmii_rx_dv = 1'b0;
        tick(4);
        tx_req = 1'b1; tx_done = 1'b1;
        tick();
        tx_req = 1'b0; tx_done = 1'b0;
        total++; if ({busy, tx_data} !== {1'b0, 8'h77}) begin
            bad++; $display("FAIL one_req_done got busy=%0h data=%0h exp 0/77", busy, tx_data);
        end
    endtask

    task automatic test_back_to_back;
        int s0, d0;
        s0 = start_seen; d0 = drop_cnt;
        send_bytes(16, 16'd16, 8'hA0);
        gmii_rx_dv = 1'b0;
        tick(4);
        send_bytes(8, 16'd8, 8'h55);
        gmii_rx_dv = 1'b0;
        total++; if (drop_cnt !== 16'(d0 + 1)) begin bad++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, d0 + 1); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0h exp=1", busy); end
        for (int i = 0; i < 16; i++) begin
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
            total++; if (tx_data !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, tx_data, 8'hA0 + 8'(i)); end
            tick();
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if ({busy, 32'(start_seen)} !== {1'b0, 32'(s0 + 1)}) begin
            bad++; $display("FAIL b2b_end got busy=%0h starts=%0d exp 0/%0d", busy, start_seen, s0 + 1);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        send_bytes(4, 16'd4, 8'h10);
        gmii_rx_dv = 1'b0;
        tick(3);
        total++; if (t_tx_start_en !== 1'b1) begin bad++; $display("FAIL to_start got=%0h exp=1", t_tx_start_en); end
        tick(17);
        total++; if (t_busy !== 1'b1) begin bad++; $display("FAIL to_busy_before got=%0h exp=1", t_busy); end
        tick();
        total++; if (t_busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0h exp=0", t_busy); end
        send_bytes(3, 16'd3, 8'h20);
        gmii_rx_dv = 1'b0;
        tick(3);
        total++; if ({t_tx_start_en, t_tx_byte_num, t_drop_cnt} !== {1'b1, 16'd3, 16'd0}) begin
            bad++; $display("FAIL to_next got start=%0h num=%0d drop=%0d exp 1/3/0", t_tx_start_en, t_tx_byte_num, t_drop_cnt);
        end
    endtask

    task automatic test_reset_settle;
        int s0;
        do_reset();
        icmp_id = 16'h1234; icmp_seq = 16'h5678;
        send_bytes(4, 16'd4, 8'h30);
        gmii_rx_dv = 1'b0;
        tick();
        total++; if ({busy, tx_id} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL rs_settle got busy=%0h id=%0h exp 1/1234", busy, tx_id); end
        rst_n = 1'b0;
        #1;
        total++; if ({busy, tx_start_en, tx_byte_num, tx_id, tx_seq, tx_checksum, tx_data, drop_cnt} !== '0) begin
            bad++; $display("FAIL rs_async got busy=%0h start=%0h num=%0h id=%0h seq=%0h ck=%0h data=%0h drop=%0h exp all 0",
                            busy, tx_start_en, tx_byte_num, tx_id, tx_seq, tx_checksum, tx_data, drop_cnt);
        end
        tick();
        rst_n = 1'b1;
        s0 = start_seen;
        tick(10);
        total++; if ({busy, 32'(start_seen)} !== {1'b0, 32'(s0)}) begin
            bad++; $display("FAIL rs_no_start got busy=%0h starts=%0d exp 0/%0d", busy, start_seen, s0);
        end
        send_bytes(2, 16'd2, 8'h90);
        gmii_rx_dv = 1'b0;
        tick(3);
        total++; if (tx_start_en !== 1'b1) begin bad++; $display("FAIL rs_fresh got=%0h exp=1", tx_start_en); end
        tx_done = 1'b1;
        tick(2);
        tx_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_overflow();
        test_single_byte();
        test_back_to_back();
        test_timeout();
        test_reset_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icmp_echo_ctrl.md
Name: icmp_echo_ctrl

Overview:
- Sequences one ICMP echo transaction between the ICMP receive parser and the ICMP transmit builder.
- Buffers the echo-request payload bytes and captures the id, seq and raw payload checksum once they are stable.
- Issues one start pulse to the transmitter, then serves its byte-read requests until it reports done.
- Single-transaction engine: requests arriving while busy are dropped and counted.

Parameters:
- DEPTH, 1472: payload buffer size in bytes; also the maximum accepted payload.
- AW, 11: buffer address width; requires 2^AW >= DEPTH.
- CKSUM_SETTLE, 2: cycles to wait after gmii_rx_dv falls before sampling reply_checksum.
- TX_TIMEOUT, 65535: cycles allowed in TX without tx_done before abort.

Ports:
- clk  in  1  system clock (GMII rx clock domain)
- rst_n  in  1  asynchronous active-low reset
- gmii_rx_dv  in  1  raw receive data-valid, used only to detect end of frame
- rec_en  in  1  payload byte strobe from parser
- rec_data  in  8  payload byte
- rec_pkt_done  in  1  one-cycle pulse, coincident with the last rec_en
- rec_byte_num  in  16  payload length, valid with rec_pkt_done
- icmp_id  in  16  echo identifier
- icmp_seq  in  16  echo sequence
- reply_checksum  in  32  unfolded payload word sum
- tx_req  in  1  transmitter requests the next payload byte
- tx_done  in  1  transmitter finished the frame
- tx_start_en  out  1  one-cycle start pulse
- tx_byte_num  out  16  payload length to echo
- tx_id  out  16  captured id
- tx_seq  out  16  captured seq
- tx_checksum  out  32  captured reply_checksum
- tx_data  out  8  payload byte, 1 cycle after tx_req
- busy  out  1  high in every state except IDLE
- drop_cnt  out  16  dropped-request counter, saturating at 16'hFFFF

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; write count, read address, overflow flag, settle counter and timeout counter all 0. Reset mid-transaction abandons it, and the buffer contents become don't-care.
- States: IDLE, RECV, DROP_WAIT, WAIT_DV, SETTLE, START, TX.
- IDLE:
  - rec_en writes mem[0], sets wr_cnt=1, goes to RECV.
  - If rec_pkt_done is coincident, apply the RECV done-check in the same cycle.
- RECV:
  - Each rec_en with wr_cnt<DEPTH writes mem[wr_cnt] and increments wr_cnt.
  - Each rec_en with wr_cnt==DEPTH sets ovf and does not write.
  - On rec_pkt_done, the coincident byte counts first. Accept if !ovf and rec_byte_num == wr_cnt (including that byte).
  - On accept: latch tx_byte_num, tx_id, tx_seq; go to WAIT_DV.
  - On reject: drop_cnt+1; go to DROP_WAIT.
- DROP_WAIT: when gmii_rx_dv==0, clear wr_cnt and ovf; go to IDLE.
- WAIT_DV: when gmii_rx_dv==0, load the settle counter with CKSUM_SETTLE-1; go to SETTLE.
- SETTLE: decrement the counter; when it reaches 0, latch reply_checksum into tx_checksum; go to START.
- START: tx_start_en=1 for exactly one cycle; clear rd_addr and the timeout counter; go to TX.
- TX:
  - tx_req: tx_data <= mem[rd_addr]; rd_addr+1. tx_req is ignored once rd_addr==tx_byte_num.
  - tx_done, or timeout counter == TX_TIMEOUT: go to IDLE, clear wr_cnt, rd_addr and ovf.
  - tx_done and tx_req in the same cycle: the read is served, then exit.
- Busy behaviour:
  - In WAIT_DV, SETTLE, START and TX, rec_en is ignored (buffer protected).
  - rec_pkt_done in those states increments drop_cnt.
- tx_id, tx_seq, tx_byte_num and tx_checksum stay stable from latch until the next accept.
- Buffer: single-port-write / single-port-read synchronous RAM, with write and read never in the same state.

Decomposition:
- Shared package constants: FSM state encodings (one-hot, 7 bits), ETH_MTU_PAYLOAD=1472.
- One sub-module: icmp_echo_buf, a simple dual-port RAM of DEPTH x 8 with registered read. Port list: clk, we, waddr, wdata, raddr, rdata.

Test Plan:
- Nominal 32-byte payload 00..1F, id=0x0001, seq=0x0005, checksum=0x0001_0F0F stable 1 cycle after dv low.
  - Expected: tx_start_en pulses once, CKSUM_SETTLE+1 cycles after dv falls.
  - Outputs: tx_byte_num=32, tx_checksum=0x00010F0F.
  - 32 tx_req yield 00..1F, each 1 cycle later; busy drops after tx_done.
- Length mismatch: 10 rec_en strobes, rec_byte_num=12.
  - Expected: drop_cnt=1, no tx_start_en; FSM in IDLE once dv is low.
- Overflow: DEPTH+1 bytes with matching rec_byte_num.
  - Expected: dropped, drop_cnt+1, no start.
- Second request while in TX: second frame's rec_en/rec_pkt_done arrive.
  - Expected: buffer unchanged (first payload reads back intact), drop_cnt+1.
- Timeout: no tx_done for TX_TIMEOUT cycles (override TX_TIMEOUT=16).
  - Expected: return to IDLE at cycle 16; the next frame is accepted normally.
- Reset asserted in SETTLE.
  - Expected: all outputs 0 immediately; no tx_start_en after release until a fresh frame arrives.
